// File: rtl/alarm_pkg.sv
// Shared constants and state encoding for the alarm trigger controller.
// Ports: none (package only).
// Provides time-field widths, FSM state constants and a saturating counter helper.
package alarm_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_RINGING = 2'd2;
  localparam state_t ST_SNOOZE  = 2'd3;

  // Two-bit increment that sticks at 3.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter with zero and last-second flags.
// Ports: clk/rst, load + load_val (load wins over dec), dec (1 Hz enable),
//        zero (count==0), last (count==1, the next dec reaches zero).
module alarm_sec_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      // A tick landing on the load cycle is dropped: loading takes priority.
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/alarm_trigger_ctrl.sv
// Alarm sequencer: compares clock time with alarm time and runs the
// IDLE/ARMED/RINGING/SNOOZE machine that drives the alarm player enable.
// Ports: clk, rst (sync, active-high), tick_1hz, alarm_arm, cur_hr/min/sec,
//        alm_hr/min, snooze_btn, stop_btn -> player_en, snoozing, ring_cnt.
// Optional: define SNOOZE_LIMIT_EN to refuse snoozes once ring_cnt==MAX_SNOOZE.
module alarm_trigger_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             alarm_arm,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [HR_W-1:0]  alm_hr,
  input  logic [MIN_W-1:0] alm_min,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  output logic             player_en,
  output logic             snoozing,
  output logic [1:0]       ring_cnt
);

  localparam int SNZ_LOAD = SNOOZE_MIN * 60;
  localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);

  state_t     state;
  state_t     nxt;
  logic [1:0] cnt_nxt;
  logic       match;
  logic       match_d;
  logic       trigger;
  logic       snooze_ok;
  logic       ring_load, ring_dec, ring_zero, ring_last, ring_expire;
  logic       snz_load, snz_dec, snz_zero, snz_last, snz_expire;

  // Rising edge of the match so a held time value fires only once.
  assign match   = (cur_hr == alm_hr) && (cur_min == alm_min) && (cur_sec == '0);
  assign trigger = match && !match_d;

`ifdef SNOOZE_LIMIT_EN
  assign snooze_ok = snooze_btn && (int'(ring_cnt) != MAX_SNOOZE);
`else
  assign snooze_ok = snooze_btn;
`endif

  assign ring_dec = tick_1hz && (state == ST_RINGING);
  assign snz_dec  = tick_1hz && (state == ST_SNOOZE);

  // Expire on the tick that takes the count to zero. The zero term is a
  // safety net: a ringing/snoozing timer already at zero ends immediately.
  assign ring_expire = (ring_dec && ring_last) || ring_zero;
  assign snz_expire  = (snz_dec && snz_last) || snz_zero;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    nxt = ST_ARMED;
      ST_ARMED:   if (trigger) nxt = ST_RINGING;
      ST_RINGING: begin
        if (stop_btn)         nxt = ST_ARMED;
        else if (snooze_ok)   nxt = ST_SNOOZE;
        else if (ring_expire) nxt = ST_ARMED;
      end
      ST_SNOOZE: begin
        if (stop_btn)        nxt = ST_ARMED;
        else if (snz_expire) nxt = ST_RINGING;
      end
      default:    nxt = ST_IDLE;
    endcase
    if (!alarm_arm) nxt = ST_IDLE;
  end

  // Timers load on entry to their state, decided from the final next state.
  assign ring_load = (nxt == ST_RINGING) && (state != ST_RINGING);
  assign snz_load  = (nxt == ST_SNOOZE) && (state != ST_SNOOZE);

  always_comb begin
    cnt_nxt = ring_cnt;
    if (!alarm_arm)
      cnt_nxt = 2'd0;
    else if ((state == ST_ARMED) && (nxt == ST_RINGING))
      cnt_nxt = 2'd0;
    else if ((state == ST_RINGING) && (nxt == ST_SNOOZE))
      cnt_nxt = sat_inc2(ring_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      match_d   <= 1'b0;
      player_en <= 1'b0;
      snoozing  <= 1'b0;
      ring_cnt  <= 2'd0;
    end else begin
      state     <= nxt;
      match_d   <= match;
      player_en <= (nxt == ST_RINGING);
      snoozing  <= (nxt == ST_SNOOZE);
      ring_cnt  <= cnt_nxt;
    end
  end

  alarm_sec_timer #(.W(8)) u_ring_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ring_load),
    .load_val (8'(RING_TIMEOUT_S)),
    .dec      (ring_dec),
    .zero     (ring_zero),
    .last     (ring_last)
  );

  alarm_sec_timer #(.W(SNZ_W)) u_snooze_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (snz_load),
    .load_val (SNZ_W'(SNZ_LOAD)),
    .dec      (snz_dec),
    .zero     (snz_zero),
    .last     (snz_last)
  );

endmodule
